// File: rtl/lab5_2_case_demux_stream_pkg.sv
// -----------------------------------------------------------------------------
// lab5_pkg
// Shared definitions for the lab5 mux/demux blocks.
//   NUM_LANES  : number of output lanes of the demultiplexer
//   LANE_IDX_W : bits needed to address one lane
//   lane_idx_t : lane index type, shared with the mux labs
//   next_lane  : round-robin successor of a lane index (wraps 3 -> 0)
// -----------------------------------------------------------------------------
package lab5_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_IDX_W = 2;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // The index is exactly LANE_IDX_W bits wide, so dropping the carry
    // gives the wrap from the last lane back to lane 0.
    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return lane_idx_t'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/lab5_2_case_demux_stream_if.sv
// -----------------------------------------------------------------------------
// lab5_2_case_demux_stream_if
// Bundles the producer-side stream, the four consumer lanes and the status
// outputs of the 1-to-4 stream demultiplexer.
//   master : producer/consumer side (drives in_*, sel, rr_mode, out_ready)
//   slave  : the demultiplexer itself
//
// Handshake: a beat moves across a valid/ready pair in every cycle where both
// valid and ready are high at the rising clock edge. A holder of valid keeps
// the beat and valid stable until it is taken. On the input side ready may
// depend combinationally on sel/rr_mode/out_ready, so the producer must not
// derive in_valid from in_ready.
// -----------------------------------------------------------------------------
interface lab5_2_case_demux_stream_if
    import lab5_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);

    logic [DATA_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
    lane_idx_t            sel;
    logic                 rr_mode;
    logic [DATA_W-1:0]    out0;
    logic [DATA_W-1:0]    out1;
    logic [DATA_W-1:0]    out2;
    logic [DATA_W-1:0]    out3;
    logic [NUM_LANES-1:0] out_valid;
    logic [NUM_LANES-1:0] out_ready;
    lane_idx_t            rr_ptr;
    logic [CNT_W-1:0]     xfer_count;

    modport master (
        output in_data, in_valid, sel, rr_mode, out_ready,
        input  in_ready, out0, out1, out2, out3, out_valid, rr_ptr, xfer_count
    );

    modport slave (
        input  in_data, in_valid, sel, rr_mode, out_ready,
        output in_ready, out0, out1, out2, out3, out_valid, rr_ptr, xfer_count
    );

endinterface

// File: rtl/lab5_2_case_demux_stream_lane_reg.sv
// -----------------------------------------------------------------------------
// demux_lane_reg
// Single-entry valid/ready holding register for one demultiplexer lane.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_data this cycle (the lane's ready was already
//               accounted for by the caller)
//   load_data : beat to capture
//   drain     : consumer takes the held beat this cycle
//   valid     : register holds a beat
//   data      : held beat, stable while valid & ~drain
// -----------------------------------------------------------------------------
module demux_lane_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Load wins over drain: a drain and reload in the same cycle is a
    // pass-through, so valid stays high with the new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lab5_2_case_demux_stream.sv
// -----------------------------------------------------------------------------
// lab5_2_case_demux_stream
// Registered 1-to-4 stream demultiplexer. One beat per cycle is accepted on
// the input stream and routed to one of four single-entry lane registers,
// chosen by sel or, when rr_mode is set, by an internal round-robin pointer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of lab5_2_case_demux_stream_if
//              in_data/in_valid/in_ready - producer stream
//              sel, rr_mode              - destination control
//              out0..out3/out_valid/out_ready - four consumer lanes
//              rr_ptr                    - current round-robin pointer
//              xfer_count                - accepted beats since reset (wraps)
// -----------------------------------------------------------------------------
module lab5_2_case_demux_stream
    import lab5_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    lab5_2_case_demux_stream_if.slave   bus
);

    lane_idx_t            dest;
    logic [NUM_LANES-1:0] dest_oh;
    logic [NUM_LANES-1:0] lane_valid;
    logic [DATA_W-1:0]    lane_data [NUM_LANES];
    logic                 in_ready;
    logic                 accept;
    lane_idx_t            rr_ptr_q;
    logic [CNT_W-1:0]     xfer_q;

    // Destination decode. The default arm is unreachable with a 2-bit index
    // but keeps X on sel from leaving dest_oh undefined.
    always_comb begin
        dest = bus.rr_mode ? rr_ptr_q : bus.sel;
        case (dest)
            2'd0:    dest_oh = 4'b0001;
            2'd1:    dest_oh = 4'b0010;
            2'd2:    dest_oh = 4'b0100;
            2'd3:    dest_oh = 4'b1000;
            default: dest_oh = 4'b0001;
        endcase
    end

    // The destination lane can take a beat if it is empty or being drained
    // in this same cycle; the other lanes do not matter.
    assign in_ready = |(dest_oh & (~lane_valid | bus.out_ready));
    assign accept   = bus.in_valid & in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane_reg #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (accept & dest_oh[k]),
            .load_data (bus.in_data),
            .drain     (bus.out_ready[k]),
            .valid     (lane_valid[k]),
            .data      (lane_data[k])
        );
    end

    // Pointer only moves on round-robin accepts; toggling rr_mode leaves it
    // where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (accept && bus.rr_mode) begin
            rr_ptr_q <= next_lane(rr_ptr_q);
        end
    end

    // Free-running accepted-beat counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_q <= '0;
        end else if (accept) begin
            xfer_q <= xfer_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0       = lane_data[0];
    assign bus.out1       = lane_data[1];
    assign bus.out2       = lane_data[2];
    assign bus.out3       = lane_data[3];
    assign bus.out_valid  = lane_valid;
    assign bus.rr_ptr     = rr_ptr_q;
    assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_lab5_2_case_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_lab5_2_case_demux_stream
// Self-checking bench for lab5_2_case_demux_stream: a directed vector table,
// hand-written reset/wrap sequences and randomized traffic against a
// lane-array reference model. A second instance with CNT_W=4 covers the
// counter wrap.
// -----------------------------------------------------------------------------
module tb_lab5_2_case_demux_stream;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    lab5_2_case_demux_stream_if #(.DATA_W(8), .CNT_W(16)) bus ();
    lab5_2_case_demux_stream_if #(.DATA_W(8), .CNT_W(4))  bus_w ();

    lab5_2_case_demux_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lab5_2_case_demux_stream #(.DATA_W(8), .CNT_W(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_out(input int k);
        case (k)
            0:       return bus.out0;
            1:       return bus.out1;
            2:       return bus.out2;
            default: return bus.out3;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Each lane is a one-slot mailbox; the pointer and counter are integers.
    bit       m_full [4];
    bit [7:0] m_data [4];
    int       m_ptr;
    int       m_cnt;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_data[k] = 8'h00;
        end
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // One clock cycle with the given inputs, checked against the model.
    task automatic step(input bit v, input bit [7:0] d, input bit [1:0] s,
                        input bit rr, input bit [3:0] rdy);
        int  dst;
        bit  exp_ir;
        bit  acc;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.sel       = s;
        bus.rr_mode   = rr;
        bus.out_ready = rdy;
        dst    = rr ? m_ptr : int'(s);
        exp_ir = !m_full[dst] || rdy[dst];
        acc    = v && exp_ir;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (acc && dst == k) begin
                m_full[k] = 1;
                m_data[k] = d;
            end else if (m_full[k] && rdy[k]) begin
                m_full[k] = 0;
            end
        end
        if (acc) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (rr) m_ptr = (m_ptr + 1) % 4;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(m_full[k]));
            if (m_full[k])
                check($sformatf("out%0d", k), 32'(dut_out(k)), 32'(m_data[k]));
        end
        check("rr_ptr", 32'(bus.rr_ptr), 32'(m_ptr));
        check("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus_w.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       v;
        bit [7:0] d;
        bit [1:0] sel;
        bit       rr;
        bit [3:0] rdy;
        bit       exp_ir;
        bit [3:0] exp_ov;
        bit [1:0] exp_lane;
        bit [7:0] exp_data;
        bit [1:0] exp_ptr;
        int       exp_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(bit v, bit [7:0] d, bit [1:0] s, bit rr, bit [3:0] rdy,
                                bit ir, bit [3:0] ov, bit [1:0] ln, bit [7:0] dat,
                                bit [1:0] p, int c);
        vec_t r;
        r.v = v; r.d = d; r.sel = s; r.rr = rr; r.rdy = rdy;
        r.exp_ir = ir; r.exp_ov = ov; r.exp_lane = ln; r.exp_data = dat;
        r.exp_ptr = p; r.exp_cnt = c;
        return r;
    endfunction

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sel       = '0;
        bus.rr_mode   = 1'b0;
        bus.out_ready = '0;
        bus_w.in_valid  = 1'b0;
        bus_w.in_data   = '0;
        bus_w.sel       = '0;
        bus_w.rr_mode   = 1'b0;
        bus_w.out_ready = '0;

        //             v  data  sel rr  rdy      ir ov       lane data  ptr cnt
        // sel mode, all consumers ready
        vecs[0]  = mk(1, 8'hAA, 0, 0, 4'b1111, 1, 4'b0001, 0, 8'hAA, 0, 1);
        vecs[1]  = mk(1, 8'hB1, 1, 0, 4'b1111, 1, 4'b0010, 1, 8'hB1, 0, 2);
        vecs[2]  = mk(1, 8'hC2, 2, 0, 4'b1111, 1, 4'b0100, 2, 8'hC2, 0, 3);
        vecs[3]  = mk(1, 8'hD3, 3, 0, 4'b1111, 1, 4'b1000, 3, 8'hD3, 0, 4);
        // backpressure on lane 2, then release with a same-cycle reload
        vecs[4]  = mk(1, 8'h11, 2, 0, 4'b1011, 1, 4'b0100, 2, 8'h11, 0, 5);
        vecs[5]  = mk(1, 8'h22, 2, 0, 4'b1011, 0, 4'b0100, 2, 8'h11, 0, 5);
        vecs[6]  = mk(1, 8'h22, 2, 0, 4'b1111, 1, 4'b0100, 2, 8'h22, 0, 6);
        // round-robin, six beats
        vecs[7]  = mk(1, 8'h01, 0, 1, 4'b1111, 1, 4'b0001, 0, 8'h01, 1, 7);
        vecs[8]  = mk(1, 8'h02, 0, 1, 4'b1111, 1, 4'b0010, 1, 8'h02, 2, 8);
        vecs[9]  = mk(1, 8'h03, 0, 1, 4'b1111, 1, 4'b0100, 2, 8'h03, 3, 9);
        vecs[10] = mk(1, 8'h04, 0, 1, 4'b1111, 1, 4'b1000, 3, 8'h04, 0, 10);
        vecs[11] = mk(1, 8'h05, 0, 1, 4'b1111, 1, 4'b0001, 0, 8'h05, 1, 11);
        vecs[12] = mk(1, 8'h06, 0, 1, 4'b1111, 1, 4'b0010, 1, 8'h06, 2, 12);
        // idle drain, then walk the pointer round to 1
        vecs[13] = mk(0, 8'h00, 0, 1, 4'b1111, 1, 4'b0000, 0, 8'h00, 2, 12);
        vecs[14] = mk(1, 8'h07, 0, 1, 4'b1111, 1, 4'b0100, 2, 8'h07, 3, 13);
        vecs[15] = mk(1, 8'h08, 0, 1, 4'b1111, 1, 4'b1000, 3, 8'h08, 0, 14);
        vecs[16] = mk(1, 8'h09, 0, 1, 4'b1111, 1, 4'b0001, 0, 8'h09, 1, 15);
        // fill lane 1 by sel and stall it; rr at pointer 1 blocks, sel=3 passes
        vecs[17] = mk(1, 8'h0A, 1, 0, 4'b1101, 1, 4'b0010, 1, 8'h0A, 1, 16);
        vecs[18] = mk(1, 8'h0B, 1, 1, 4'b1101, 0, 4'b0010, 1, 8'h0A, 1, 16);
        vecs[19] = mk(1, 8'h0B, 3, 0, 4'b1101, 1, 4'b1010, 3, 8'h0B, 1, 17);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset rr_ptr", 32'(bus.rr_ptr), 32'h0);
        check("reset xfer_count", 32'(bus.xfer_count), 32'h0);
        check("reset in_ready", 32'(bus.in_ready), 32'h1);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.in_valid  = vecs[i].v;
            bus.in_data   = vecs[i].d;
            bus.sel       = vecs[i].sel;
            bus.rr_mode   = vecs[i].rr;
            bus.out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov[vecs[i].exp_lane])
                check($sformatf("vec%0d out%0d", i, vecs[i].exp_lane),
                      32'(dut_out(int'(vecs[i].exp_lane))), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d rr_ptr", i), 32'(bus.rr_ptr), 32'(vecs[i].exp_ptr));
            check($sformatf("vec%0d xfer_count", i), 32'(bus.xfer_count), 32'(vecs[i].exp_cnt));
        end
        // lane 1 must still hold its stalled beat after the lane 3 accept
        check("stalled out1 held", 32'(bus.out1), 32'h0A);

        // ---------------- reset mid-operation ----------------
        do_reset();
        step(1, 8'h31, 1, 0, 4'b1111);
        step(1, 8'h32, 2, 0, 4'b1111);
        step(1, 8'h33, 1, 0, 4'b1111);
        step(1, 8'h34, 2, 0, 4'b1111);
        step(1, 8'h35, 1, 0, 4'b1111);
        step(1, 8'hC0, 0, 0, 4'b0110);
        step(1, 8'hC3, 3, 0, 4'b0110);
        check("pre-reset out_valid", 32'(bus.out_valid), 32'h9);
        check("pre-reset xfer_count", 32'(bus.xfer_count), 32'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("mid-reset out_valid", 32'(bus.out_valid), 32'h0);
        check("mid-reset out0", 32'(bus.out0), 32'h0);
        check("mid-reset out3", 32'(bus.out3), 32'h0);
        check("mid-reset rr_ptr", 32'(bus.rr_ptr), 32'h0);
        check("mid-reset xfer_count", 32'(bus.xfer_count), 32'h0);
        check("mid-reset in_ready", 32'(bus.in_ready), 32'h1);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        // ---------------- counter wrap, CNT_W=4 ----------------
        do_reset();
        @(negedge clk);
        bus_w.sel       = 2'd0;
        bus_w.rr_mode   = 1'b0;
        bus_w.out_ready = 4'b1111;
        bus_w.in_valid  = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            bus_w.in_data = 8'(i);
            @(posedge clk);
            #1;
            if (i == 16) check("wrap count after 16", 32'(bus_w.xfer_count), 32'd0);
            @(negedge clk);
        end
        bus_w.in_valid = 1'b0;
        check("wrap count after 17", 32'(bus_w.xfer_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
